// File: rtl/uart_rx_pkt_ctrl.sv
// Purpose: unloads words from the UART receiver, drops parity errors, runs config writes/reads, forwards the rest.
// Latency: IDLE sees a waiting word -> data tx_valid / cfg_we after 2 cycles, read reply tx_valid after 4 cycles.
// Backpressure: tx_valid holds tx_data until tx_ready; no new word is unloaded until the packet has been handed off.
module uart_rx_pkt_ctrl #(
    parameter int         WIDTH        = 64,
    parameter logic [7:0] BROADCAST_ID = 8'hFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_enable,
    input  logic [7:0]       chip_id,
    input  logic [WIDTH-2:0] rx_data,
    input  logic             rx_empty,
    input  logic             parity_error,
    output logic             uld_rx_data,
    output logic             cfg_we,
    output logic             cfg_re,
    output logic [7:0]       cfg_addr,
    output logic [7:0]       cfg_wdata,
    input  logic [7:0]       cfg_rdata,
    output logic [WIDTH-2:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       err_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        CFG_WR  = 3'd2,
        CFG_RD  = 3'd3,
        RD_WAIT = 3'd4,
        FWD     = 3'd5
    } state_t;

    localparam logic [1:0] TYPE_CFG_WR = 2'b10;
    localparam logic [1:0] TYPE_CFG_RD = 2'b11;

    state_t           state;
    logic [WIDTH-2:0] pkt;
    logic             perr;
    logic             id_match;

    // Config packets are taken by this chip when addressed to it or broadcast
    assign id_match = (pkt[9:2] == chip_id) || (pkt[9:2] == BROADCAST_ID);

    // Packet sequencer: one word in flight at a time, every output registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pkt         <= '0;
            perr        <= 1'b0;
            uld_rx_data <= 1'b0;
            cfg_we      <= 1'b0;
            cfg_re      <= 1'b0;
            cfg_addr    <= 8'h00;
            cfg_wdata   <= 8'h00;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            err_cnt     <= 8'h00;
        end else begin
            // Strobes are single-cycle pulses unless a state re-asserts them
            uld_rx_data <= 1'b0;
            cfg_we      <= 1'b0;
            cfg_re      <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_enable && !rx_empty) begin
                        pkt         <= rx_data;
                        perr        <= parity_error;
                        uld_rx_data <= 1'b1;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (perr) begin
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state <= IDLE;
                    end else if (pkt[1:0] == TYPE_CFG_WR && id_match) begin
                        cfg_we    <= 1'b1;
                        cfg_addr  <= pkt[17:10];
                        cfg_wdata <= pkt[25:18];
                        state     <= CFG_WR;
                    end else if (pkt[1:0] == TYPE_CFG_RD && id_match) begin
                        cfg_re   <= 1'b1;
                        cfg_addr <= pkt[17:10];
                        state    <= CFG_RD;
                    end else begin
                        tx_data  <= pkt;
                        tx_valid <= 1'b1;
                        state    <= FWD;
                    end
                end
                CFG_WR: begin
                    state <= IDLE;
                end
                CFG_RD: begin
                    // cfg_rdata becomes valid during the following cycle
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Reply carries the read byte in the data field and the downstream marker set
                    pkt[25:18]    <= cfg_rdata;
                    pkt[WIDTH-2]  <= 1'b1;
                    tx_data       <= {1'b1, pkt[WIDTH-3:26], cfg_rdata, pkt[17:0]};
                    tx_valid      <= 1'b1;
                    state         <= FWD;
                end
                FWD: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
